// File: rtl/mem_access_ctrl_if.sv
// Bundle between the MEM stage, the access controller and the word-only data RAM.
// master is the controller's view; slave is the view of the pipeline/RAM environment.
interface mem_access_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_i;
    logic [2:0]        op_i;
    logic [ADDR_W-1:0] addr_i;
    logic [31:0]       wdata_i;
    logic              stall_o;
    logic              done_o;
    logic              err_o;
    logic [31:0]       rdata_o;
    logic              ram_ce_o;
    logic              ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [31:0]       ram_data_o;
    logic [31:0]       ram_data_i;
    logic              ram_ack_i;

    modport master (
        input  req_i, op_i, addr_i, wdata_i, ram_data_i, ram_ack_i,
        output stall_o, done_o, err_o, rdata_o, ram_ce_o, ram_we_o, ram_addr_o, ram_data_o
    );

    modport slave (
        output req_i, op_i, addr_i, wdata_i, ram_data_i, ram_ack_i,
        input  stall_o, done_o, err_o, rdata_o, ram_ce_o, ram_we_o, ram_addr_o, ram_data_o
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage bus initiator: turns one byte/half/word load or store into word-RAM
// transactions (sub-word stores as read-modify-write) and returns the extended load data.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_ctrl_if.master  bus
);
    localparam logic [2:0] OpLb  = 3'b000;
    localparam logic [2:0] OpLbu = 3'b001;
    localparam logic [2:0] OpLh  = 3'b010;
    localparam logic [2:0] OpLhu = 3'b011;
    localparam logic [2:0] OpLw  = 3'b100;
    localparam logic [2:0] OpSb  = 3'b101;
    localparam logic [2:0] OpSh  = 3'b110;
    localparam logic [2:0] OpSw  = 3'b111;

    typedef enum logic [2:0] {StIdle, StRdA, StRdB, StWrA, StWrB, StDone} state_e;

    state_e            state_q;
    logic [2:0]        op_q;
    logic [1:0]        addr_lo_q;
    logic [15:0]       wdata_lo_q;
    logic              ram_ce_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [31:0]       ram_data_q;
    logic              done_q;
    logic              err_q;
    logic [31:0]       rdata_q;

    logic              misaligned;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_ext;
    logic [31:0]       merged;

    always_comb begin
        misaligned = 1'b0;
        unique case (bus.op_i)
            OpLh, OpLhu, OpSh: misaligned = bus.addr_i[0];
            OpLw, OpSw:        misaligned = (bus.addr_i[1:0] != 2'b00);
            default:           misaligned = 1'b0;
        endcase
    end

    // Big-endian lane selection on the word returned by the RAM
    always_comb begin
        byte_sel = 8'h00;
        unique case (addr_lo_q)
            2'b00:   byte_sel = bus.ram_data_i[31:24];
            2'b01:   byte_sel = bus.ram_data_i[23:16];
            2'b10:   byte_sel = bus.ram_data_i[15:8];
            default: byte_sel = bus.ram_data_i[7:0];
        endcase
        half_sel = addr_lo_q[1] ? bus.ram_data_i[15:0] : bus.ram_data_i[31:16];

        load_ext = bus.ram_data_i;
        unique case (op_q)
            OpLb:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            OpLbu:   load_ext = {24'h000000, byte_sel};
            OpLh:    load_ext = {{16{half_sel[15]}}, half_sel};
            OpLhu:   load_ext = {16'h0000, half_sel};
            default: load_ext = bus.ram_data_i;
        endcase
    end

    always_comb begin
        merged = bus.ram_data_i;
        if (op_q == OpSb) begin
            unique case (addr_lo_q)
                2'b00:   merged[31:24] = wdata_lo_q[7:0];
                2'b01:   merged[23:16] = wdata_lo_q[7:0];
                2'b10:   merged[15:8]  = wdata_lo_q[7:0];
                default: merged[7:0]   = wdata_lo_q[7:0];
            endcase
        end else if (op_q == OpSh) begin
            if (addr_lo_q[1]) merged[15:0]  = wdata_lo_q;
            else              merged[31:16] = wdata_lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            op_q       <= OpLb;
            addr_lo_q  <= 2'b00;
            wdata_lo_q <= 16'h0000;
            ram_ce_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= 32'h0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (bus.req_i) begin
                        op_q       <= bus.op_i;
                        addr_lo_q  <= bus.addr_i[1:0];
                        wdata_lo_q <= bus.wdata_i[15:0];
                        if (misaligned) begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            ram_addr_q <= {bus.addr_i[ADDR_W-1:2], 2'b00};
                            ram_ce_q   <= 1'b1;
                            if (bus.op_i == OpSw) begin
                                ram_we_q   <= 1'b1;
                                ram_data_q <= bus.wdata_i;
                                state_q    <= StWrA;
                            end else begin
                                ram_we_q <= 1'b0;
                                state_q  <= StRdA;
                            end
                        end
                    end
                end
                StRdA: begin
                    ram_ce_q <= 1'b0;
                    state_q  <= StRdB;
                end
                StRdB: begin
                    if ((op_q == OpSb) || (op_q == OpSh)) begin
                        ram_data_q <= merged;
                        ram_ce_q   <= 1'b1;
                        ram_we_q   <= 1'b1;
                        state_q    <= StWrA;
                    end else begin
                        rdata_q <= load_ext;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                // The RAM always holds ack low in the first write cycle
                StWrA: state_q <= StWrB;
                StWrB: begin
                    if (bus.ram_ack_i) begin
                        ram_ce_q <= 1'b0;
                        ram_we_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Gated by reset so the pipeline is never held while the block is in reset
    assign bus.stall_o = rst && (((state_q == StIdle) && bus.req_i) ||
                                 (state_q == StRdA) || (state_q == StRdB) ||
                                 (state_q == StWrA) || (state_q == StWrB));

    assign bus.done_o     = done_q;
    assign bus.err_o      = err_q;
    assign bus.rdata_o    = rdata_q;
    assign bus.ram_ce_o   = ram_ce_q;
    assign bus.ram_we_o   = ram_we_q;
    assign bus.ram_addr_o = ram_addr_q;
    assign bus.ram_data_o = ram_data_q;
endmodule
